paritiy3_frame_rx: RTL and testbench

//  Serial receiver stage directly downstream of the 3-bit parity generator.

---
 rtl/paritiy3_frame_rx.sv | 111 +++++++++++
 tb/tb_paritiy3_frame_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/paritiy3_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits MSB-first, parity, stop(1).
// Delivers the deserialised word with a one-cycle valid pulse and held error flags.
module paritiy3_frame_rx #(
  parameter int DATA_W = 3,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  // Handshake: valid is a single-cycle strobe with no back-pressure; data,
  // parity_err and frame_err are stable from a valid cycle until the next one.

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              par_bit;
  logic              par_bit_nxt;
  logic              frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift   <= shift_nxt;
      par_bit <= par_bit_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    par_bit_nxt = par_bit;
    frame_done  = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!rx) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          // Truncating the concatenation keeps the newest DATA_W bits.
          shift_nxt = DATA_W'({shift, rx});
          if (cnt == LAST_BIT) begin
            cnt_nxt   = '0;
            state_nxt = PARITY;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          par_bit_nxt = rx;
          state_nxt   = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Result registers move only on the stop-bit edge, so they hold between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= frame_done;
      if (frame_done) begin
        data       <= shift;
        parity_err <= par_bit ^ (^shift) ^ ODD;
        frame_err  <= ~rx;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_paritiy3_frame_rx.sv
// Bench for paritiy3_frame_rx: directed frames plus randomized frames with
// a queue-based scoreboard and an independent output monitor.
module tb_paritiy3_frame_rx;

  localparam int DATA_W = 3;
  localparam bit ODD    = 1'b0;
  localparam int EW     = DATA_W + 2;

  logic              clk    = 1'b0;
  logic              reset  = 1'b1;
  logic              bit_en = 1'b0;
  logic              rx     = 1'b1;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] exp_q[$];
  int  rst_count = 0;
  bit  mon_on = 1'b0;
  int  cyc = 0;
  int  valid_cnt = 0;
  int  last_cyc = 0;
  int  prev_cyc = 0;

  paritiy3_frame_rx #(.DATA_W(DATA_W), .ODD(ODD)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the word as sent, parity checked against the word's own parity.
  function automatic logic [EW-1:0] model(input logic [DATA_W-1:0] d, input bit p, input bit stop);
    bit want_p;
    want_p = ODD ? ~(^d) : (^d);
    return {d, (p != want_p), ~stop};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Driver tasks: inputs change on the falling edge.
  task automatic send_bit(input bit b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
    @(negedge clk);
    rx     = b;
    bit_en = 1'b1;
  endtask

  task automatic end_strobe();
    @(negedge clk);
    bit_en = 1'b0;
    rx     = 1'b1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input bit p, input bit stop, input int gap);
    send_bit(1'b0, gap);
    @(posedge clk);
    #1;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
    exp_q.push_back(model(d, p, stop));
    send_bit(stop, gap);
  endtask

  task automatic check_idle();
    end_strobe();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: samples just after the rising edge.
  initial begin
    logic [EW-1:0] held;
    int  seen_rst;
    bit  prev_valid;
    held       = '0;
    seen_rst   = 0;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (rst_count != seen_rst) begin
          seen_rst = rst_count;
          held     = '0;
        end
        if (valid) begin
          check("valid_width", 32'(prev_valid), 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_valid: got valid=1 expected no frame at cycle %0d", cyc);
          end else begin
            held = exp_q.pop_front();
          end
          valid_cnt++;
          prev_cyc = last_cyc;
          last_cyc = cyc;
        end
        check("outputs", 32'({data, parity_err, frame_err}), 32'(held));
        prev_valid = valid;
      end
    end
  end

  initial begin
    int snap;
    int budget;
    logic [DATA_W-1:0] d;
    bit p;
    bit stop;
    int gap;

    // Reset, then idle line with strobes every cycle
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;
    rx     = 1'b1;
    bit_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("busy_reset_idle", 32'(busy), 32'd0);
    end
    bit_en = 1'b0;

    // Good frame, bad parity, bad stop
    send_frame(3'b101, 1'b0, 1'b1, 0);
    check_idle();
    send_frame(3'b110, 1'b1, 1'b1, 0);
    check_idle();
    send_frame(3'b011, 1'b0, 1'b0, 0);
    check_idle();

    // Back-to-back frames
    snap = valid_cnt;
    send_frame(3'b001, 1'b1, 1'b1, 0);
    send_frame(3'b111, 1'b1, 1'b1, 0);
    check_idle();
    repeat (3) @(negedge clk);
    check("b2b_valid_count", 32'(valid_cnt - snap), 32'd2);
    check("b2b_spacing", 32'(last_cyc - prev_cyc), 32'(DATA_W + 3));

    // Reset in the middle of a frame, then a full frame
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    bit_en = 1'b0;
    reset  = 1'b1;
    rst_count++;
    @(negedge clk);
    reset = 1'b0;
    check("busy_after_abort", 32'(busy), 32'd0);
    send_frame(3'b010, 1'b1, 1'b1, 0);
    check_idle();

    // Sparse strobes: one every 4th cycle
    send_frame(3'b101, 1'b0, 1'b1, 3);
    check_idle();

    // Randomized frames, gaps and idle-line stretches
    for (int n = 0; n < 40; n++) begin
      d    = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      p    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 2);
      send_frame(d, p, stop, gap);
      if ($urandom_range(0, 2) != 0) begin
        check_idle();
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          rx     = 1'b1;
          bit_en = 1'b1;
        end
        @(negedge clk);
        bit_en = 1'b0;
      end
    end
    end_strobe();

    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
